// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI-lite initiator with watchdog abort
module axi_lite_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP} state_t;

  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done;
  logic        w_done;
  logic [31:0] wd_cnt;
  logic        timeout;
  logic        aw_done_n;
  logic        w_done_n;

  assign req_ready = (state == IDLE);
  assign rready    = (state == RDATA);
  assign bready    = (state == WRESP);
  assign araddr    = addr_q;
  assign awaddr    = addr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;

  // wd_cnt counts completed non-IDLE cycles, so this is the TIMEOUT_CYCLES-th one
  assign timeout   = WD_EN && (state != IDLE) && (wd_cnt == WD_LAST);
  assign aw_done_n = aw_done | (awvalid & awready);
  assign w_done_n  = w_done | (wvalid & wready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      arvalid    <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      wd_cnt     <= 32'd0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
    end else begin
      resp_valid <= 1'b0;
      wd_cnt     <= (state == IDLE) ? 32'd0 : wd_cnt + 32'd1;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            if (req_wen) begin
              state   <= WREQ;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              state   <= RADDR;
              arvalid <= 1'b1;
            end
          end
        end
        RADDR, WREQ: begin
          if (timeout) begin
            state      <= IDLE;
            arvalid    <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'd0;
          end else if (state == RADDR) begin
            if (arready) begin
              arvalid <= 1'b0;
              state   <= RDATA;
            end
          end else begin
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
            awvalid <= !aw_done_n;
            wvalid  <= !w_done_n;
            if (aw_done_n && w_done_n) state <= WRESP;
          end
        end
        RDATA, WRESP: begin
          // a completing beat beats a simultaneous watchdog expiry
          if (state == RDATA && rvalid) begin
            state      <= IDLE;
            resp_valid <= 1'b1;
            resp_rdata <= rdata;
            resp_err   <= rresp;
          end else if (state == WRESP && bvalid) begin
            state      <= IDLE;
            resp_valid <= 1'b1;
            resp_rdata <= 32'd0;
            resp_err   <= bresp;
          end else if (timeout) begin
            state      <= IDLE;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - self-checking bench for axi_lite_master
module tb_axi_lite_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rresp, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bresp, bvalid, bready;
  logic [3:0]  wstrb;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata = 32'd0;
  logic        last_err = 1'b0;

  axi_lite_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // One transaction from the current negedge. d1: AR/AW ready delay, d2: W ready delay,
  // d3: R/B valid delay after the address phase. Expected timing comes from the latency rules.
  task automatic run_txn(input bit wen, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] rd, input bit er,
                         input int d1, input int d2, input int d3);
    int m, nat, resp_c;
    bit tmo, e_ar, e_aw, e_w, e_rr, e_br, e_rv, e_err;
    logic [31:0] e_rd;
    m      = wen ? ((d1 > d2) ? d1 : d2) : d1;
    nat    = m + d3 + 3;
    tmo    = (nat > TO + 1);
    resp_c = tmo ? TO + 1 : nat;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_accept got %b exp 1", req_ready);
    end
    req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = wd; req_wstrb = ws;
    @(posedge clk);
    for (int c = 1; c <= resp_c; c++) begin
      @(negedge clk);
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
      e_ar = !wen && c <= 1 + d1 && c <= TO;
      e_aw = wen && c <= 1 + d1 && c <= TO;
      e_w  = wen && c <= 1 + d2 && c <= TO;
      e_rr = !wen && c >= 2 + d1 && c < resp_c;
      e_br = wen && c >= 2 + m && c < resp_c;
      e_rv = (c == resp_c);
      checks++; if (arvalid !== e_ar) begin errors++; $display("FAIL arvalid c=%0d got %b exp %b", c, arvalid, e_ar); end
      checks++; if (awvalid !== e_aw) begin errors++; $display("FAIL awvalid c=%0d got %b exp %b", c, awvalid, e_aw); end
      checks++; if (wvalid !== e_w) begin errors++; $display("FAIL wvalid c=%0d got %b exp %b", c, wvalid, e_w); end
      checks++; if (rready !== e_rr) begin errors++; $display("FAIL rready c=%0d got %b exp %b", c, rready, e_rr); end
      checks++; if (bready !== e_br) begin errors++; $display("FAIL bready c=%0d got %b exp %b", c, bready, e_br); end
      checks++; if (resp_valid !== e_rv) begin errors++; $display("FAIL resp_valid c=%0d got %b exp %b", c, resp_valid, e_rv); end
      checks++; if (req_ready !== e_rv) begin errors++; $display("FAIL req_ready c=%0d got %b exp %b", c, req_ready, e_rv); end
      if (e_ar) begin
        checks++; if (araddr !== a) begin errors++; $display("FAIL araddr got %h exp %h", araddr, a); end
      end
      if (e_aw) begin
        checks++; if (awaddr !== a) begin errors++; $display("FAIL awaddr got %h exp %h", awaddr, a); end
      end
      if (e_w) begin
        checks++; if (wdata !== wd || wstrb !== ws) begin
          errors++; $display("FAIL wdata_wstrb got %h/%h exp %h/%h", wdata, wstrb, wd, ws);
        end
      end
      if (e_rv) begin
        e_rd  = (tmo || wen) ? 32'd0 : rd;
        e_err = tmo ? 1'b1 : er;
        checks++; if (resp_rdata !== e_rd) begin errors++; $display("FAIL resp_rdata got %h exp %h", resp_rdata, e_rd); end
        checks++; if (resp_err !== e_err) begin errors++; $display("FAIL resp_err got %b exp %b", resp_err, e_err); end
        last_rdata = e_rd;
        last_err   = e_err;
      end
      arready = !wen && c == 1 + d1;
      awready = wen && c == 1 + d1;
      wready  = wen && c == 1 + d2;
      rvalid  = !wen && c == 2 + d1 + d3;
      rdata   = rvalid ? rd : $urandom;
      rresp   = rvalid ? er : 1'($urandom);
      bvalid  = wen && c == 2 + m + d3;
      bresp   = bvalid ? er : 1'($urandom);
    end
  endtask

  // Idle cycles with stray R/B beats that must be ignored; response fields must hold.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_resp_valid got %b exp 0", resp_valid); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got %b exp 1", req_ready); end
      checks++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
        errors++; $display("FAIL idle_valids got %b exp 00000", {arvalid, awvalid, wvalid, rready, bready});
      end
      checks++; if (resp_rdata !== last_rdata || resp_err !== last_err) begin
        errors++; $display("FAIL resp_hold got %h/%b exp %h/%b", resp_rdata, resp_err, last_rdata, last_err);
      end
      rvalid = 1'($urandom); bvalid = 1'($urandom); rdata = $urandom; rresp = 1'($urandom); bresp = 1'($urandom);
    end
    rvalid = 1'b0; bvalid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_wstrb = 4'd0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
    rdata = 32'd0; rresp = 1'b0; bresp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({arvalid, awvalid, wvalid, resp_valid, resp_err} !== 5'b0 || resp_rdata !== 32'd0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_state got %b/%h/%b exp 00000/0/1", {arvalid, awvalid, wvalid, resp_valid, resp_err}, resp_rdata, req_ready);
    end
    rst = 1'b0;
    last_rdata = 32'd0; last_err = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_read_basic;
    run_txn(1'b0, 32'h8000_0010, 32'd0, 4'd0, 32'hDEAD_BEEF, 1'b0, 0, 0, 0);
    idle_cycles(1);
  endtask

  task automatic test_write_basic;
    run_txn(1'b1, 32'h8000_0020, 32'h1234_5678, 4'h3, 32'd0, 1'b0, 0, 0, 0);
    idle_cycles(1);
    run_txn(1'b1, 32'h8000_0020, 32'h1234_5678, 4'h3, 32'd0, 1'b0, 3, 0, 0);
    idle_cycles(1);
    run_txn(1'b1, 32'h8000_0023, 32'hCAFE_F00D, 4'h9, 32'd0, 1'b1, 0, 2, 1);
    idle_cycles(1);
  endtask

  task automatic test_back_to_back;
    run_txn(1'b0, 32'h0000_1001, 32'd0, 4'd0, 32'hA5A5_0F0F, 1'b1, 1, 0, 1);
    run_txn(1'b1, 32'h0000_2002, 32'h5555_AAAA, 4'hF, 32'd0, 1'b0, 0, 1, 0);
    run_txn(1'b0, 32'h0000_3003, 32'd0, 4'd0, 32'h0123_4567, 1'b0, 0, 0, 0);
    idle_cycles(2);
  endtask

  task automatic test_timeout;
    run_txn(1'b0, 32'h9000_0000, 32'd0, 4'd0, 32'h1111_1111, 1'b0, 100, 0, 0);
    idle_cycles(1);
    run_txn(1'b0, 32'h9000_0004, 32'd0, 4'd0, 32'h2222_2222, 1'b0, 3, 0, 3);
    idle_cycles(1);
    run_txn(1'b0, 32'h9000_0008, 32'd0, 4'd0, 32'h3333_3333, 1'b0, 3, 0, 4);
    idle_cycles(1);
    run_txn(1'b1, 32'h9000_000C, 32'h4444_4444, 4'h1, 32'd0, 1'b0, 3, 1, 3);
    idle_cycles(1);
    run_txn(1'b1, 32'h9000_0010, 32'h5555_5555, 4'h2, 32'd0, 1'b0, 0, 0, 100);
    idle_cycles(1);
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'hB000_0000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL mid_rready got %b exp 1", rready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({arvalid, rready, resp_valid} !== 3'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got %b/%b exp 000/1", {arvalid, rready, resp_valid}, req_ready);
    end
    last_rdata = 32'd0; last_err = 1'b0;
    rvalid = 1'b1; rdata = 32'hFFFF_FFFF; rresp = 1'b1;
    idle_cycles(3);
  endtask

  task automatic test_random;
    bit wen;
    int d1, d2, d3;
    for (int i = 0; i < 24; i++) begin
      wen = 1'($urandom);
      d1  = $urandom_range(0, 3);
      d2  = $urandom_range(0, 3);
      d3  = $urandom_range(0, 2);
      run_txn(wen, $urandom, $urandom, 4'($urandom), $urandom, 1'($urandom), d1, d2, d3);
      if ($urandom_range(0, 1) == 1) idle_cycles(1);
    end
    idle_cycles(1);
  endtask

  initial begin
    test_reset;
    test_read_basic;
    test_write_basic;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
